// File: rtl/rv_cpu_pkg.sv
`default_nettype none
// rv_cpu_pkg: opcode/funct encodings, ALU op enum and ALU helper for rv_cpu.
// Revision: 1.0
package rv_cpu_pkg;

   localparam int DEF_IMEM_WORDS = 32;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;
   localparam logic [2:0] F3_WORD    = 3'b010;
   localparam logic [2:0] F3_BEQ     = 3'b000;
   localparam logic [2:0] F3_BNE     = 3'b001;

   localparam logic [6:0] F7_BASE    = 7'h00;
   localparam logic [6:0] F7_ALT     = 7'h20;

   localparam logic [31:0] NOP_INSN  = 32'h0000_0013;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_SLT = 3'd5
   } alu_op_t;

   function automatic logic [31:0] alu_eval(alu_op_t op, logic [31:0] a, logic [31:0] b);
      logic [31:0] r;
      case (op)
         ALU_SUB: r = a - b;
         ALU_AND: r = a & b;
         ALU_OR:  r = a | b;
         ALU_XOR: r = a ^ b;
         ALU_SLT: r = {31'd0, ($signed(a) < $signed(b))};
         default: r = a + b;
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/clk_gate.sv
`default_nettype none
// clk_gate: latch-based integrated clock gate; enable captured while clk is low.
// Revision: 1.0
module clk_gate (
   input  logic clk,
   input  logic en,
   output logic gclk
);
   logic en_lat;

   always_latch begin
      if (!clk) en_lat <= en;
   end

   assign gclk = clk & en_lat;

endmodule
`default_nettype wire

// File: rtl/rv_cpu.sv
`default_nettype none
// rv_cpu: single-cycle RV32I-subset core with fixed ROM, register file and data RAM; out = x10[9:0].
// Optional macro RV_CPU_CLK_GATE_EN routes the data-RAM clock through clk_gate. Revision: 1.0
module rv_cpu
   import rv_cpu_pkg::*;
#(
   parameter int IMEM_WORDS = DEF_IMEM_WORDS,
   parameter int DMEM_WORDS = 32
) (
   input  logic       clk,
   input  logic       reset,
   output logic [9:0] out
);
   localparam int PC_W = $clog2(IMEM_WORDS) + 2;
   localparam int IA_W = $clog2(IMEM_WORDS);
   localparam int DA_W = $clog2(DMEM_WORDS);
   localparam int PROG_LEN = 8;

   localparam logic [31:0] PROG [PROG_LEN] = '{
      32'h0050_0093,   // addi x1,x0,5
      32'h0030_0113,   // addi x2,x0,3
      32'h0020_8533,   // add  x10,x1,x2
      32'h4020_8533,   // sub  x10,x1,x2
      32'h00A0_2023,   // sw   x10,0(x0)
      32'h0000_2183,   // lw   x3,0(x0)
      32'h0015_0513,   // addi x10,x10,1
      32'hFE05_1EE3    // bne  x10,x0,-4
   };

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2
   } wb_sel_t;

   logic [PC_W-1:0] pc;
   logic [31:0]     regs [32];
   logic [31:0]     dmem [DMEM_WORDS];

   logic [IA_W-1:0] rom_idx;
   logic [31:0]     instr;
   logic [6:0]      opcode;
   logic [4:0]      rd, rs1, rs2;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [31:0]     imm_i, imm_s, imm_b, imm_j;

   logic            reg_we, mem_we, use_imm, branch_taken, jump;
   alu_op_t         alu_op;
   wb_sel_t         wb_sel;
   logic [31:0]     imm;

   logic [31:0]     rs1_val, rs2_val, alu_b, alu_res, wb_data;
   logic [31:0]     pc_ext, pc_plus4, pc_target;
   logic [PC_W-1:0] pc_next;
   logic [DA_W-1:0] dm_idx;
   logic [31:0]     rdata;
   logic            ram_clk;

   assign rom_idx = pc[PC_W-1:2];

   always_comb begin
      instr = NOP_INSN;
      if (int'(rom_idx) < PROG_LEN) instr = PROG[rom_idx[2:0]];
   end

   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign funct3 = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign funct7 = instr[31:25];
   assign imm_i  = {{20{instr[31]}}, instr[31:20]};
   assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   assign rs1_val = regs[rs1];
   assign rs2_val = regs[rs2];

   // Anything not explicitly matched below falls through as a NOP.
   always_comb begin
      reg_we       = 1'b0;
      mem_we       = 1'b0;
      use_imm      = 1'b0;
      branch_taken = 1'b0;
      jump         = 1'b0;
      alu_op       = ALU_ADD;
      wb_sel       = WB_ALU;
      imm          = imm_i;
      case (opcode)
         OPC_OP: begin
            if (funct7 == F7_BASE) begin
               reg_we = 1'b1;
               case (funct3)
                  F3_ADD_SUB: alu_op = ALU_ADD;
                  F3_SLT:     alu_op = ALU_SLT;
                  F3_XOR:     alu_op = ALU_XOR;
                  F3_OR:      alu_op = ALU_OR;
                  F3_AND:     alu_op = ALU_AND;
                  default:    reg_we = 1'b0;
               endcase
            end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
               reg_we = 1'b1;
               alu_op = ALU_SUB;
            end
         end
         OPC_OP_IMM: begin
            if (funct3 == F3_ADD_SUB) begin
               reg_we  = 1'b1;
               use_imm = 1'b1;
            end
         end
         OPC_LOAD: begin
            if (funct3 == F3_WORD) begin
               reg_we  = 1'b1;
               use_imm = 1'b1;
               wb_sel  = WB_MEM;
            end
         end
         OPC_STORE: begin
            if (funct3 == F3_WORD) begin
               mem_we  = 1'b1;
               use_imm = 1'b1;
               imm     = imm_s;
            end
         end
         OPC_BRANCH: begin
            imm = imm_b;
            if (funct3 == F3_BEQ)      branch_taken = (rs1_val == rs2_val);
            else if (funct3 == F3_BNE) branch_taken = (rs1_val != rs2_val);
         end
         OPC_JAL: begin
            reg_we = 1'b1;
            jump   = 1'b1;
            wb_sel = WB_PC4;
            imm    = imm_j;
         end
         default: ;
      endcase
   end

   assign alu_b   = use_imm ? imm : rs2_val;
   assign alu_res = alu_eval(alu_op, rs1_val, alu_b);

   assign pc_ext    = {{(32-PC_W){1'b0}}, pc};
   assign pc_plus4  = pc_ext + 32'd4;
   assign pc_target = pc_ext + imm;
   assign pc_next   = (branch_taken || jump) ? pc_target[PC_W-1:0] : pc_plus4[PC_W-1:0];

   assign dm_idx = alu_res[DA_W+1:2];
   assign rdata  = dmem[dm_idx];

   always_comb begin
      case (wb_sel)
         WB_MEM:  wb_data = rdata;
         WB_PC4:  wb_data = pc_plus4;
         default: wb_data = alu_res;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc <= '0;
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else begin
         pc <= pc_next;
         if (reg_we && rd != 5'd0) regs[rd] <= wb_data;
      end
   end

`ifdef RV_CPU_CLK_GATE_EN
   // Gate opens for stores and for reset so the RAM clear still sees an edge.
   clk_gate u_clk_gate (
      .clk  (clk),
      .en   (mem_we | ~reset),
      .gclk (ram_clk)
   );
`else
   assign ram_clk = clk;
`endif

   always_ff @(posedge ram_clk) begin
      if (!reset) begin
         for (int i = 0; i < DMEM_WORDS; i++) dmem[i] <= '0;
      end else if (mem_we) begin
         dmem[dm_idx] <= rs2_val;
      end
   end

   assign out = regs[10][9:0];

   logic unused_bits;
   assign unused_bits = ^{alu_res[31:DA_W+2], alu_res[1:0], pc_target[31:PC_W], pc_plus4[31:PC_W]};

endmodule
`default_nettype wire

// File: tb/tb_rv_cpu.sv
`default_nettype none
// tb_rv_cpu: directed self-checking bench for the rv_cpu demo program.
// Revision: 1.0
module tb_rv_cpu;

   logic       clk;
   logic       reset;
   logic [9:0] out;

   int checks   = 0;
   int failures = 0;

   // x10[9:0] after edges 1..20 of the fixed program.
   localparam logic [9:0] SEQ [20] = '{
      10'd0, 10'd0, 10'd8, 10'd2, 10'd2, 10'd2, 10'd3, 10'd3, 10'd4, 10'd4,
      10'd5, 10'd5, 10'd6, 10'd6, 10'd7, 10'd7, 10'd8, 10'd8, 10'd9, 10'd9
   };

   rv_cpu dut (
      .clk   (clk),
      .reset (reset),
      .out   (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (10) step();
      checks++;
      if (out !== 10'd0) begin failures++; $display("FAIL reset_out got=%0d exp=0", out); end
      checks++;
      if (dut.regs[3] !== 32'd0) begin failures++; $display("FAIL reset_x3 got=%0d exp=0", dut.regs[3]); end
      checks++;
      if (dut.dmem[0] !== 32'd0) begin failures++; $display("FAIL reset_ram0 got=%0d exp=0", dut.dmem[0]); end
   endtask

   task automatic test_program();
      reset = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         step();
         checks++;
         if (out !== SEQ[e-1]) begin
            failures++;
            $display("FAIL program_edge%0d got=%0d exp=%0d", e, out, SEQ[e-1]);
         end
         if (e == 6) begin
            checks++;
            if (dut.regs[3] !== 32'd2) begin failures++; $display("FAIL load_x3 got=%0d exp=2", dut.regs[3]); end
            checks++;
            if (dut.dmem[0] !== 32'd2) begin failures++; $display("FAIL store_ram0 got=%0d exp=2", dut.dmem[0]); end
         end
      end
      checks++;
      if (dut.regs[0] !== 32'd0) begin failures++; $display("FAIL x0_zero got=%0d exp=0", dut.regs[0]); end
   endtask

   task automatic test_reset_pulse();
      reset = 1'b0;
      step();
      reset = 1'b1;
      repeat (15) step();
      checks++;
      if (out !== 10'd7) begin failures++; $display("FAIL pulse_pre got=%0d exp=7", out); end
      reset = 1'b0;
      step();
      checks++;
      if (out !== 10'd0) begin failures++; $display("FAIL pulse_out got=%0d exp=0", out); end
      checks++;
      if (dut.regs[3] !== 32'd0) begin failures++; $display("FAIL pulse_x3 got=%0d exp=0", dut.regs[3]); end
      checks++;
      if (dut.dmem[0] !== 32'd0) begin failures++; $display("FAIL pulse_ram0 got=%0d exp=0", dut.dmem[0]); end
      reset = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         step();
         checks++;
         if (out !== SEQ[e-1]) begin
            failures++;
            $display("FAIL pulse_edge%0d got=%0d exp=%0d", e, out, SEQ[e-1]);
         end
      end
   endtask

   task automatic test_reset_priority();
      reset = 1'b0;
      step();
      reset = 1'b1;
      repeat (4) step();
      // Next edge would retire the store; reset must win.
      reset = 1'b0;
      step();
      checks++;
      if (dut.dmem[0] !== 32'd0) begin failures++; $display("FAIL prio_ram0 got=%0d exp=0", dut.dmem[0]); end
      checks++;
      if (out !== 10'd0) begin failures++; $display("FAIL prio_out got=%0d exp=0", out); end
   endtask

   task automatic test_wrap();
      reset = 1'b0;
      step();
      reset = 1'b1;
      for (int e = 1; e <= 2100; e++) begin
         step();
         if (e == 2047 || e == 2048) begin
            checks++;
            if (out !== 10'd1023) begin failures++; $display("FAIL wrap_edge%0d got=%0d exp=1023", e, out); end
         end
         if (e == 2049) begin
            checks++;
            if (out !== 10'd0) begin failures++; $display("FAIL wrap_out got=%0d exp=0", out); end
            checks++;
            if (dut.regs[10] !== 32'd1024) begin failures++; $display("FAIL wrap_x10 got=%0d exp=1024", dut.regs[10]); end
         end
      end
      checks++;
      if (out !== 10'd25) begin failures++; $display("FAIL wrap_edge2100 got=%0d exp=25", out); end
   endtask

   initial begin
      reset = 1'b0;
      test_reset();
      test_program();
      test_reset_pulse();
      test_reset_priority();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
